// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the core load/store path has priority, and a waiting host
// request is forced through after MAX_WAIT cycles at the cost of a one-cycle core stall.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state_o,
  output logic [WAIT_W-1:0] dbg_wait_cnt_o
);

  // Host handshake: host_req is raised with stable we/addr/wdata and held until
  // host_gnt; the access happens in the grant cycle. Read data returns one cycle
  // later as a single host_rvalid pulse. A new request may follow directly.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] WAIT_ZERO = '0;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                host_own;
  logic                host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= WAIT_ZERO;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    host_own   = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_req && !core_req) begin
          host_own = 1'b1;
        end else if (host_req && core_req) begin
          state_d    = PEND;
          wait_cnt_d = WAIT_ONE;
        end
      end
      PEND: begin
        // A dropped request abandons the wait rather than granting a stale access.
        if (!host_req) begin
          state_d    = IDLE;
          wait_cnt_d = WAIT_ZERO;
        end else if (!core_req) begin
          host_own   = 1'b1;
          state_d    = IDLE;
          wait_cnt_d = WAIT_ZERO;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          state_d = FORCE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      FORCE: begin
        host_own   = 1'b1;
        state_d    = IDLE;
        wait_cnt_d = WAIT_ZERO;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = WAIT_ZERO;
      end
    endcase
  end

  always_comb begin
    host_rvalid_d = host_own && !host_we;
    host_rdata_d  = host_rdata_q;
    if (host_own && !host_we) begin
      host_rdata_d = mem_rdata;
    end
  end

  always_comb begin
    if (host_own) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else begin
      mem_we    = core_req & core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  assign host_gnt       = host_own;
  assign core_stall     = core_req && host_own;
  assign core_rdata     = mem_rdata;
  assign host_rvalid    = host_rvalid_q;
  assign host_rdata     = host_rdata_q;
  assign dbg_state_o    = state_q;
  assign dbg_wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural data memory, a host read-data
// scoreboard, and cycle-exact checks of grant timing, stalls and the memory mux.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;
  localparam int WAIT_W   = 4;

  logic              clk;
  logic              rst;
  logic              core_req, core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic              core_stall;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        dbg_state;
  logic [WAIT_W-1:0] dbg_wait_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state), .dbg_wait_cnt_o(dbg_wait_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural data memory ----------------
  logic [DATA_W-1:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic req, input logic we,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    core_req   = req;
    core_we    = we;
    core_addr  = addr;
    core_wdata = wdata;
  endtask

  task automatic drive_host(input logic req, input logic we,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    host_req   = req;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  // ---------------- scoreboard: host read returns ----------------
  always @(negedge clk) begin
    if (host_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_without_read", 64'(exp_q.size()), 64'd1);
      end else begin
        chk("host_rdata", 64'(host_rdata), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic prev_stall;
    logic exp_gnt;

    rst = 1'b1;
    drive_core(1'b0, 1'b0, '0, '0);
    drive_host(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_wait_cnt", 64'(dbg_wait_cnt), 64'd0);
    chk("rst_rvalid", 64'(host_rvalid), 64'd0);
    chk("rst_rdata", 64'(host_rdata), 64'd0);
    chk("rst_gnt", 64'(host_gnt), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    rst = 1'b0;

    // Host write then read of 0x10 with the core idle.
    drive_host(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    chk("t1_wr_gnt", 64'(host_gnt), 64'd1);
    chk("t1_wr_mem_we", 64'(mem_we), 64'd1);
    chk("t1_wr_mem_addr", 64'(mem_addr), 64'h10);
    chk("t1_wr_stall", 64'(core_stall), 64'd0);
    tick();
    chk("t1_no_wr_rvalid", 64'(host_rvalid), 64'd0);
    drive_host(1'b1, 1'b0, 32'h10, '0);
    #1;
    chk("t1_rd_gnt", 64'(host_gnt), 64'd1);
    chk("t1_rd_mem_we", 64'(mem_we), 64'd0);
    exp_q.push_back(32'hDEADBEEF);
    tick();
    drive_host(1'b0, 1'b0, '0, '0);
    #1;
    chk("t1_rvalid_pulse", 64'(host_rvalid), 64'd1);
    tick();
    chk("t1_rvalid_drop", 64'(host_rvalid), 64'd0);

    // Core stores to 0x20 every cycle; host read of 0x20 is forced after MAX_WAIT.
    drive_core(1'b1, 1'b1, 32'h20, 32'hCAFE0020);
    drive_host(1'b1, 1'b0, 32'h20, '0);
    for (int k = 0; k <= MAX_WAIT; k++) begin
      #1;
      chk($sformatf("t2_gnt_k%0d", k), 64'(host_gnt), 64'(k == MAX_WAIT));
      chk($sformatf("t2_stall_k%0d", k), 64'(core_stall), 64'(k == MAX_WAIT));
      if (k == 3) chk("t2_wait_cnt_k3", 64'(dbg_wait_cnt), 64'd3);
      if (k == MAX_WAIT) begin
        chk("t2_force_state", 64'(dbg_state), 64'd2);
        chk("t2_force_mem_we", 64'(mem_we), 64'd0);
        exp_q.push_back(32'hCAFE0020);
      end
      tick();
    end
    drive_host(1'b0, 1'b0, '0, '0);
    #1;
    chk("t2_after_state", 64'(dbg_state), 64'd0);
    chk("t2_after_stall", 64'(core_stall), 64'd0);
    chk("t2_core_store_we", 64'(mem_we), 64'd1);
    chk("t2_core_store_addr", 64'(mem_addr), 64'h20);
    tick();
    drive_core(1'b0, 1'b0, '0, '0);
    tick();

    // Simultaneous core load and host write of 0x10 from IDLE: core wins.
    drive_core(1'b1, 1'b0, 32'h10, '0);
    drive_host(1'b1, 1'b1, 32'h10, 32'h11112222);
    #1;
    chk("t3_core_rdata", 64'(core_rdata), 64'hDEADBEEF);
    chk("t3_gnt", 64'(host_gnt), 64'd0);
    chk("t3_stall", 64'(core_stall), 64'd0);
    chk("t3_mem_we", 64'(mem_we), 64'd0);
    tick();
    chk("t3_pend_state", 64'(dbg_state), 64'd1);
    chk("t3_pend_cnt", 64'(dbg_wait_cnt), 64'd1);
    drive_core(1'b0, 1'b0, '0, '0);
    #1;
    chk("t3_late_gnt", 64'(host_gnt), 64'd1);
    chk("t3_late_we", 64'(mem_we), 64'd1);
    chk("t3_late_wdata", 64'(mem_wdata), 64'h11112222);
    tick();
    drive_host(1'b0, 1'b0, '0, '0);
    #1;
    chk("t3_idle_state", 64'(dbg_state), 64'd0);
    chk("t3_mem_content", 64'(mem[4]), 64'h11112222);
    tick();

    // Asynchronous reset while PEND with wait_cnt=5, then a full wait restarts.
    drive_core(1'b1, 1'b1, 32'h30, 32'h55550030);
    drive_host(1'b1, 1'b0, 32'h30, '0);
    for (int k = 0; k < 5; k++) tick();
    chk("t4_pre_state", 64'(dbg_state), 64'd1);
    chk("t4_pre_cnt", 64'(dbg_wait_cnt), 64'd5);
    rst = 1'b1;
    #1;
    chk("t4_rst_state", 64'(dbg_state), 64'd0);
    chk("t4_rst_cnt", 64'(dbg_wait_cnt), 64'd0);
    chk("t4_rst_rvalid", 64'(host_rvalid), 64'd0);
    chk("t4_rst_gnt", 64'(host_gnt), 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k <= MAX_WAIT; k++) begin
      #1;
      chk($sformatf("t4_gnt_k%0d", k), 64'(host_gnt), 64'(k == MAX_WAIT));
      if (k == MAX_WAIT) exp_q.push_back(32'h55550030);
      tick();
    end
    drive_host(1'b0, 1'b0, '0, '0);
    drive_core(1'b0, 1'b0, '0, '0);
    tick();

    // Back-to-back host writes then reads of 0x0/0x4/0x8/0xC with the core idle.
    for (int i = 0; i < 4; i++) begin
      drive_host(1'b1, 1'b1, 32'(i * 4), 32'hA0A00000 | 32'(i));
      #1;
      chk($sformatf("t5_wr_gnt%0d", i), 64'(host_gnt), 64'd1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive_host(1'b1, 1'b0, 32'(i * 4), '0);
      #1;
      chk($sformatf("t5_rd_gnt%0d", i), 64'(host_gnt), 64'd1);
      chk($sformatf("t5_rvalid%0d", i), 64'(host_rvalid), 64'(i != 0));
      exp_q.push_back(32'hA0A00000 | 32'(i));
      tick();
    end
    drive_host(1'b0, 1'b0, '0, '0);
    #1;
    chk("t5_last_rvalid", 64'(host_rvalid), 64'd1);
    tick();

    // Sustained contention: forced grant every MAX_WAIT+1 cycles, never two stalls in a row.
    drive_core(1'b1, 1'b1, 32'h40, 32'h77770040);
    drive_host(1'b1, 1'b0, 32'hC, '0);
    prev_stall = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      exp_gnt = ((k % (MAX_WAIT + 1)) == MAX_WAIT);
      chk($sformatf("t6_gnt_k%0d", k), 64'(host_gnt), 64'(exp_gnt));
      chk($sformatf("t6_dbl_stall_k%0d", k), 64'(prev_stall && core_stall), 64'd0);
      chk($sformatf("t6_mux_addr_k%0d", k), 64'(mem_addr), exp_gnt ? 64'hC : 64'h40);
      chk($sformatf("t6_mux_we_k%0d", k), 64'(mem_we), exp_gnt ? 64'd0 : 64'd1);
      if (exp_gnt) exp_q.push_back(32'hA0A00003);
      prev_stall = core_stall;
      tick();
    end
    drive_host(1'b0, 1'b0, '0, '0);
    drive_core(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
